// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO stream reader.
package fifo_stream_reader_pkg;
   localparam int OCC_W     = 2;   // width of the buffer occupancy count
   localparam int BUF_DEPTH = 2;   // output buffer entries
   localparam int CNT_W     = 16;  // default burst beat counter width

   typedef logic [OCC_W-1:0] occ_t;

   // Words buffered or in flight once the current-cycle fire has left.
   function automatic logic [2:0] credit_after_fire(occ_t occ, logic inflight, logic fire);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, fire};
   endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying data words with a burst-end marker.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry ordered output buffer (head/tail) that absorbs the RAM read latency.
module fifo_stream_reader_skid_buf2
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output occ_t                  occ_o
);
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   occ_t                  occ_q, occ_d;

   // Next state: push fills the first free slot, pop shifts tail into head.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (clr_i) begin
         occ_d = '0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (occ_q == 2'd0) head_d = push_data_i;
               else               tail_d = push_data_i;
               occ_d = occ_q + 2'd1;
            end
            2'b01: begin
               if (occ_q == 2'd2) head_d = tail_q;
               occ_d = occ_q - 2'd1;
            end
            2'b11: begin
               // Occupancy stays put; the new word lands behind whatever remains.
               if (occ_q == 2'd1) begin
                  head_d = push_data_i;
               end else begin
                  head_d = tail_q;
                  tail_d = push_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head_o = head_q;
   assign occ_o  = occ_q;

   // A capture into a full buffer without a fire would lose a word.
   assert property (@(posedge clk_i) disable iff (rst_i)
      !(occ_q == occ_t'(BUF_DEPTH) && push_i && !pop_i));
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream with burst markers.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int CNT_BITS   = CNT_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fifo_empty_i,
   input  logic                  fifo_error_i,
   input  logic [DATA_WIDTH-1:0] fifo_pop_data_i,
   output logic                  fifo_pop_req_o,
   input  logic                  flush_i,
   fifo_stream_reader_if.master  m_if,
   output occ_t                  buf_occ_o,
   output logic                  err_sticky_o
);
   localparam logic [CNT_BITS-1:0] LAST_BEAT =
      (BURST_LEN == 0) ? '0 : CNT_BITS'(BURST_LEN - 1);

   logic                  fire;
   logic                  capture;
   logic                  inflight_q, inflight_d;
   logic                  err_q, err_d;
   logic [CNT_BITS-1:0]   beat_cnt_q, beat_cnt_d;
   logic [DATA_WIDTH-1:0] head;
   occ_t                  occ;

   assign fire = m_if.valid & m_if.ready;

   // A word returning during a flush belongs to the discarded stream, and no
   // pop is issued in the flush cycle, so masking capture by flush_i is the
   // whole discard mechanism.
   assign capture = inflight_q & ~flush_i;

   // Pop only while buffer + in-flight words, after this cycle's fire, leave a
   // free slot. Looking at fire makes ready reach the pop combinationally,
   // which is what keeps the stream at one word per cycle.
   assign fifo_pop_req_o = ~fifo_empty_i & ~flush_i & ~rst_i &
                           (credit_after_fire(occ, inflight_q, fire) < 3'd2);

   assign inflight_d = fifo_pop_req_o;
   assign err_d      = err_q | fifo_error_i;

   // Beat counter advances on each delivered word and restarts on flush.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (flush_i)
         beat_cnt_d = '0;
      else if (fire && BURST_LEN != 0)
         beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_BITS'(1);
   end

   // Pop tracking, burst position and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_q <= 1'b0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   fifo_stream_reader_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (flush_i),
      .push_i      (capture),
      .push_data_i (fifo_pop_data_i),
      .pop_i       (fire),
      .head_o      (head),
      .occ_o       (occ)
   );

   assign m_if.valid   = (occ != '0);
   assign m_if.data    = head;
   assign m_if.last    = m_if.valid & (BURST_LEN != 0) & (beat_cnt_q == LAST_BEAT);
   assign buf_occ_o    = occ;
   assign err_sticky_o = err_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: FIFO model, per-cycle vector table and burst sequences.
module tb_fifo_stream_reader;
   import fifo_stream_reader_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst, fifo_error, flush, fifo_clear;
   logic          fifo_empty, pop_req, err;
   logic [DW-1:0] pop_data;
   occ_t          occ;

   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

   fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(16), .CNT_BITS(16)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .fifo_empty_i    (fifo_empty),
      .fifo_error_i    (fifo_error),
      .fifo_pop_data_i (pop_data),
      .fifo_pop_req_o  (pop_req),
      .flush_i         (flush),
      .m_if            (s_if),
      .buf_occ_o       (occ),
      .err_sticky_o    (err)
   );

   // FIFO model: pop data appears the cycle after the request.
   logic [DW-1:0] mem [0:255];
   logic [7:0]    rd_ptr = 8'd0;
   logic [7:0]    wr_ptr = 8'd0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_clear) rd_ptr <= wr_ptr;
      else if (pop_req && !fifo_empty) begin
         pop_data <= mem[rd_ptr];
         rd_ptr   <= rd_ptr + 8'd1;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic inv();
      chk("no_pop_when_empty", 32'(pop_req & fifo_empty), 32'd0);
      chk("occ_max2", 32'(occ == 2'd3), 32'd0);
   endtask

   task automatic preload(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = base + 32'(i);
         wr_ptr      = wr_ptr + 8'd1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; fifo_clear = 1'b1; fifo_error = 1'b0; s_if.ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; fifo_clear = 1'b0;
   endtask

   // Stream with ready held high; checks order, first-valid latency and gap-free beats.
   task automatic stream_burst(input string nm, input logic [31:0] base, input int n, input int last_idx);
      int k = 0;
      int first = -1;
      int lastc = -1;
      s_if.ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #1;
         inv();
         if (s_if.valid) begin
            if (first < 0) first = c;
            lastc = c;
            chk({nm, "_data"}, s_if.data, base + 32'(k));
            chk({nm, "_last"}, 32'(s_if.last), 32'(k == last_idx));
            k++;
         end
         @(posedge clk); #1;
      end
      chk({nm, "_first_valid_cycle"}, 32'(first), 32'd2);
      chk({nm, "_beats"}, 32'(k), 32'(n));
      chk({nm, "_back_to_back"}, 32'(lastc - first), 32'(n - 1));
   endtask

   typedef struct {
      logic        ready;
      logic        exp_pop;
      logic        exp_valid;
      logic [1:0]  exp_occ;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [15];

   initial begin
      int k;
      logic        stalled;
      logic [31:0] held;

      // Four words A0..A3, consumer stalled 10 cycles then ready.
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'hA0};
      for (int i = 3; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'hA0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'hA0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'hA1};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'hA2};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'hA3};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0};

      // Reset state
      do_reset();
      #1;
      chk("rst_valid", 32'(s_if.valid), 32'd0);
      chk("rst_occ",   32'(occ), 32'd0);
      chk("rst_data",  s_if.data, 32'd0);
      chk("rst_last",  32'(s_if.last), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_pop",   32'(pop_req), 32'd0);

      // Stalled consumer: exactly two pops, then drain in order
      preload(32'hA0, 4);
      for (int i = 0; i < 15; i++) begin
         s_if.ready = tbl[i].ready;
         #1;
         inv();
         chk($sformatf("t3_pop[%0d]", i),   32'(pop_req),    32'(tbl[i].exp_pop));
         chk($sformatf("t3_valid[%0d]", i), 32'(s_if.valid), 32'(tbl[i].exp_valid));
         chk($sformatf("t3_occ[%0d]", i),   32'(occ),        32'(tbl[i].exp_occ));
         if (tbl[i].exp_valid) begin
            chk($sformatf("t3_data[%0d]", i), s_if.data, tbl[i].exp_data);
            chk($sformatf("t3_last[%0d]", i), 32'(s_if.last), 32'd0);
         end
         @(posedge clk); #1;
      end

      // Full 16-word burst at full rate, M_LAST on the last word
      do_reset();
      preload(32'h10, 16);
      stream_burst("t1", 32'h10, 16, 15);

      // Toggling ready: no loss/duplication, data held while stalled
      do_reset();
      preload(32'h20, 8);
      k = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 40; c++) begin
         s_if.ready = ((c % 2) == 0);
         #1;
         inv();
         if (stalled) begin
            chk("t2_valid_hold", 32'(s_if.valid), 32'd1);
            chk("t2_stable", s_if.data, held);
         end
         if (s_if.valid && s_if.ready) begin
            chk("t2_data", s_if.data, 32'h20 + 32'(k));
            k++;
         end
         stalled = s_if.valid & ~s_if.ready;
         held    = s_if.data;
         @(posedge clk); #1;
      end
      chk("t2_count", 32'(k), 32'd8);
      chk("t2_occ_end", 32'(occ), 32'd0);

      // Flush with a pop in flight
      do_reset();
      preload(32'h30, 16);
      s_if.ready = 1'b1;
      k = 0;
      for (int c = 0; c < 7; c++) begin
         #1;
         inv();
         if (s_if.valid) begin
            chk("t4_data", s_if.data, 32'h30 + 32'(k));
            k++;
         end
         @(posedge clk); #1;
      end
      chk("t4_delivered", 32'(k), 32'd5);
      s_if.ready = 1'b0; flush = 1'b1; fifo_clear = 1'b1;
      #1;
      chk("t4_no_pop_in_flush", 32'(pop_req), 32'd0);
      chk("t4_head_at_flush", s_if.data, 32'h35);
      @(posedge clk); #1;
      flush = 1'b0; fifo_clear = 1'b0;
      #1;
      chk("t4_valid_after", 32'(s_if.valid), 32'd0);
      chk("t4_occ_after", 32'(occ), 32'd0);
      @(posedge clk); #1;
      #1;
      chk("t4_inflight_dropped", 32'(occ), 32'd0);
      preload(32'h40, 16);
      stream_burst("t4b", 32'h40, 16, 15);

      // Reset mid-stream with a full buffer
      do_reset();
      preload(32'h50, 4);
      for (int c = 0; c < 5; c++) begin
         #1; inv();
         @(posedge clk); #1;
      end
      #1;
      chk("t5_occ_full", 32'(occ), 32'd2);
      chk("t5_head", s_if.data, 32'h50);
      rst = 1'b1;
      #1;
      chk("t5_no_pop_in_reset", 32'(pop_req), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("t5_valid", 32'(s_if.valid), 32'd0);
      chk("t5_occ",   32'(occ), 32'd0);
      chk("t5_data",  s_if.data, 32'd0);
      chk("t5_last",  32'(s_if.last), 32'd0);
      chk("t5_err",   32'(err), 32'd0);
      stream_burst("t5s", 32'h52, 2, -1);

      // One-cycle FIFO error latches and leaves the data path alone
      do_reset();
      preload(32'h60, 8);
      s_if.ready = 1'b1;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         fifo_error = (c == 3);
         #1;
         inv();
         chk("t6_err", 32'(err), 32'(c >= 4));
         if (s_if.valid) begin
            chk("t6_data", s_if.data, 32'h60 + 32'(k));
            k++;
         end
         @(posedge clk); #1;
      end
      fifo_error = 1'b0;
      chk("t6_count", 32'(k), 32'd8);
      do_reset();
      #1;
      chk("t6_err_cleared", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
